// File: rtl/xgcd_job_sequencer.sv
// XGCD job sequencer: fetches ARG_A/ARG_B word pairs from the operand SRAM, streams
// them to the XGCD datapath, then reports status, DONE_OUT and IRQ.
// Optional WAIT_DONE watchdog is built when XGCD_SEQ_TIMEOUT_EN is defined.
module xgcd_job_sequencer #(
    parameter int NUM_WORDS      = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [5:0]  NWORDS,
    input  logic        IRQ_EN,
    input  logic        IRQ_CLR,
    output logic        BUSY,
    output logic        START_OUT,
    output logic        DONE_OUT,
    output logic        IRQ,
    output logic [1:0]  STATUS,
    output logic        MEM_CEn,
    output logic [11:0] MEM_ADDR,
    input  logic [63:0] MEM_RDATA,
    output logic        DP_VALID,
    input  logic        DP_READY,
    output logic [63:0] DP_A,
    output logic [63:0] DP_B,
    output logic        DP_LAST,
    input  logic        DP_DONE,
    input  logic        DP_ERR
);

    localparam int KW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_ERR    = 2'b01;
    localparam logic [1:0] ST_TMO    = 2'b10;
    localparam logic [1:0] ST_BADLEN = 2'b11;

    localparam logic [11:0] B_BASE = 12'h100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_CAP_B,
        S_PRESENT,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    // B window starts at 0x100, so more than 32 words would alias into it.
    generate
        if (NUM_WORDS < 1 || NUM_WORDS > 32) begin : g_bad_num_words
            $error("xgcd_job_sequencer: NUM_WORDS must be 1..32");
        end
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("xgcd_job_sequencer: TIMEOUT_CYCLES must fit the 16-bit watchdog");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [KW-1:0]   last_q, last_d;
    logic [63:0]     dp_a_q, dp_a_d;
    logic [63:0]     dp_b_q, dp_b_d;
    logic [1:0]      status_q, status_d;
    logic            irq_q, irq_d;
    logic            start_out_q, start_out_d;

`ifdef XGCD_SEQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]     tmo_q, tmo_d;
`endif

    logic            nwords_ok;
    logic            is_last;
    logic            mid_job;
    logic [11:0]     word_offset;

    assign nwords_ok   = (NWORDS != 6'd0) && (7'(NWORDS) <= 7'(NUM_WORDS));
    assign is_last     = (k_q == last_q);
    assign word_offset = 12'({k_q, 3'b000});

    // States in which a datapath error or a premature DP_DONE aborts the job.
    assign mid_job = (state_q == S_RD_A) || (state_q == S_RD_B) || (state_q == S_CAP_B) ||
                     (state_q == S_PRESENT) || (state_q == S_WAIT_DONE);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        last_d      = last_q;
        dp_a_d      = dp_a_q;
        dp_b_d      = dp_b_q;
        status_d    = status_q;
        irq_d       = irq_q;
        start_out_d = 1'b0;
`ifdef XGCD_SEQ_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    start_out_d = 1'b1;
                    k_d         = '0;
                    if (nwords_ok) begin
                        last_d   = KW'(NWORDS - 6'd1);
                        status_d = ST_OK;
                        state_d  = S_RD_A;
                    end else begin
                        status_d = ST_BADLEN;
                        state_d  = S_DONE;
                    end
                end
            end
            S_RD_A: begin
                state_d = S_RD_B;
            end
            S_RD_B: begin
                dp_a_d  = MEM_RDATA;
                state_d = S_CAP_B;
            end
            S_CAP_B: begin
                dp_b_d  = MEM_RDATA;
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (DP_READY) begin
                    if (is_last) begin
                        state_d = S_WAIT_DONE;
`ifdef XGCD_SEQ_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end else begin
                        k_d     = k_q + KW'(1);
                        state_d = S_RD_A;
                    end
                end
            end
`ifdef XGCD_SEQ_TIMEOUT_EN
            S_WAIT_DONE: begin
                // DP_DONE is checked first so it wins in the expiry cycle.
                if (DP_DONE) begin
                    status_d = ST_OK;
                    state_d  = S_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    status_d = ST_TMO;
                    state_d  = S_DONE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
`else
            S_WAIT_DONE: begin
                if (DP_DONE) begin
                    status_d = ST_OK;
                    state_d  = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Aborts override the normal flow; DP_ERR outranks DP_DONE.
        if (mid_job) begin
            if (DP_ERR) begin
                status_d = ST_ERR;
                state_d  = S_DONE;
            end else if (DP_DONE && (state_q != S_WAIT_DONE)) begin
                status_d = ST_ERR;
                state_d  = S_DONE;
            end
        end

        if (IRQ_CLR) begin
            irq_d = 1'b0;
        end
        if ((state_q == S_DONE) && IRQ_EN) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            last_q      <= '0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            status_q    <= ST_OK;
            irq_q       <= 1'b0;
            start_out_q <= 1'b0;
`ifdef XGCD_SEQ_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            last_q      <= last_d;
            dp_a_q      <= dp_a_d;
            dp_b_q      <= dp_b_d;
            status_q    <= status_d;
            irq_q       <= irq_d;
            start_out_q <= start_out_d;
`ifdef XGCD_SEQ_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    always_comb begin
        MEM_ADDR = 12'h000;
        if (state_q == S_RD_A) begin
            MEM_ADDR = word_offset;
        end else if (state_q == S_RD_B) begin
            MEM_ADDR = B_BASE + word_offset;
        end
    end

    assign BUSY      = (state_q != S_IDLE);
    assign START_OUT = start_out_q;
    assign DONE_OUT  = (state_q == S_DONE);
    assign IRQ       = irq_q;
    assign STATUS    = status_q;
    assign MEM_CEn   = !((state_q == S_RD_A) || (state_q == S_RD_B));
    assign DP_VALID  = (state_q == S_PRESENT);
    assign DP_A      = dp_a_q;
    assign DP_B      = dp_b_q;
    assign DP_LAST   = (state_q == S_PRESENT) && is_last;

endmodule
